fft_reorder_buf: RTL and testbench
==================================

Name: fft_reorder_buf

Overview:
Parametrised ping-pong reorder buffer placed after the R2SDF FFT pipeline. The pipeline emits bins in bit-reversed order; this block converts each frame of 2^N complex fixed-point samples to natural bin order. Output is a valid/ready stream with frame-start and frame-last markers. Frame framing follows the FFT convention: a start pulse accompanies sample 0.

Parameters:
N, 4, log2 of points per frame (16-point default); legal range 2..12
W, 16, width of each real/imag component, two's complement

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
in_start  input  1  marks sample 0 of a frame; qualified by in_valid
in_valid  input  1  input sample valid; no backpressure on input side
in_re  input  W  input real part, bit-reversed bin order
in_im  input  W  input imaginary part
out_valid  output  1  output sample valid
out_ready  input  1  downstream accept
out_start  output  1  first bin (index 0) of a frame
out_last  output  1  last bin (index 2^N-1) of a frame
out_idx  output  N  natural bin index of current output
out_re  output  W  output real part
out_im  output  W  output imaginary part
drop  output  1  one-cycle pulse when an input frame is discarded

Behaviour:
- Storage: two banks of 2^N x 2W entries. Each bank has a full flag. wr_bank and rd_bank pointers are 1 bit each.
- Write FSM states: IDLE, FILL, DROP.
  - IDLE: on in_valid&&in_start, write the sample to address 0 of wr_bank, set k=1, go to FILL. in_valid without in_start is ignored.
  - FILL: on each in_valid, write to address bitrev(k) and increment k.
  - in_valid&&in_start in FILL restarts the frame in the same bank: sample written as k=0, k=1, partial data discarded.
  - On the write with k=2^N-1: set full[wr_bank], toggle wr_bank, go to IDLE.
  - Bank availability is checked at in_start. If full[wr_bank] is still set at that point: pulse drop, go to DROP, no writes. DROP ignores samples until the next in_valid&&in_start, which is re-evaluated as in IDLE.
- Read side: when full[rd_bank] and the output register is empty or being accepted, load the entry at natural address j into the output register.
  - out_idx=j, out_start=(j==0), out_last=(j==2^N-1).
  - The transfer occurs on out_valid&&out_ready. When the transfer has out_last set, clear full[rd_bank] and toggle rd_bank.
- out_valid, out_re, out_im, out_idx, out_start and out_last hold stable while out_valid&&!out_ready.
- Latency: the last input write occurs at cycle T; full is set at T+1; out_valid is first asserted at T+2. With out_ready held high, throughput is 1 sample/cycle.
- Simultaneous events:
  - A read releasing a bank in the same cycle as in_start targeting that bank: the release wins, and the frame is accepted, not dropped.
  - A write completing one bank while the other bank is read is legal.
- Reset (including mid-frame or mid-readout): both full flags cleared, wr_bank=rd_bank=0, k=j=0, FSM IDLE. All outputs 0 on the cycle after rst is sampled high. Memory contents are don't-care.
- Arithmetic: data is stored and forwarded unchanged, with no scaling. bitrev reverses the N-bit index.

Optional Feature:
FFT_REORDER_STATS_EN
- Defined: adds output frame_cnt (16 bits), incremented on each out_last transfer and wrapping at 2^16. Also adds output drop_cnt (16 bits), incremented on each drop pulse and saturating at 16'hFFFF. Both counters clear on rst.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package fft_pkg holds:
  - function bitrev(idx, N)
  - write FSM state enum {IDLE, FILL, DROP}
  - localparam PTS = 1<<N, shared with the FFT core
- Sub-module fft_pp_ram: two-bank register-array RAM with 1 write port (bank, addr, data) and 1 read port (bank, addr). The write port uses registered writes. The read port uses a combinational read that feeds the output register in fft_reorder_buf.

Test Plan:
- N=4, W=16, one frame with in_re=k, in_im=-k for k=0..15, out_ready=1:
  - out_re order is 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; out_im is the negation of each.
  - out_start on idx 0 only, out_last on idx 15.
  - first out_valid 2 cycles after the last in_valid.
- Three back-to-back frames with out_ready=1 → all 48 outputs delivered in order, no drop pulse.
- out_ready=0 throughout, three frames sent → frames 1 and 2 stored. At in_start of frame 3: drop=1 for 1 cycle, and frame 3 samples are ignored. Then raise out_ready → frames 1 and 2 are output intact.
- Random out_ready (50%) during readout → data and out_idx hold while stalled; the sequence matches the natural-order reference exactly.
- in_start reasserted at k=7 of a frame, then 16 samples with in_re=100+k → only the 100-series frame is output; no drop.
- rst pulsed mid-readout at j=5 → next cycle all outputs 0. A subsequent fresh frame is output correctly from idx 0. With FFT_REORDER_STATS_EN, frame_cnt=0 and drop_cnt=0 after the reset.

Source files
------------

// File: rtl/fft_reorder_buf_pkg.sv
// fft_pkg: shared definitions for the FFT reorder buffer and the FFT core.
//   FFT_N / PTS  - default transform size (log2 and points per frame)
//   wr_state_e   - write-side FSM states
//   bitrev()     - reverses the low n bits of an index (n <= 12)
package fft_pkg;

    localparam int FFT_N = 4;
    localparam int PTS   = 1 << FFT_N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DROP = 2'd2
    } wr_state_e;

    // Bits at or above n stay zero, so callers can slice the low n bits.
    function automatic logic [11:0] bitrev(input logic [11:0] idx, input int n);
        logic [11:0] r;
        r = '0;
        for (int i = 0; i < 12; i++) begin
            if (i < n) begin
                r[i] = idx[n-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_buf_pp_ram.sv
// fft_pp_ram: two-bank register-array RAM for the reorder buffer.
//   clk                       - clock
//   wr_en/wr_bank/wr_addr     - registered write port
//   wr_data                   - {re, im} word to store
//   rd_bank/rd_addr           - combinational read address
//   rd_data                   - {re, im} word at the read address
// Contents are not reset.
module fft_pp_ram
    import fft_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           wr_en,
    input  logic           wr_bank,
    input  logic [N-1:0]   wr_addr,
    input  logic [2*W-1:0] wr_data,
    input  logic           rd_bank,
    input  logic [N-1:0]   rd_addr,
    output logic [2*W-1:0] rd_data
);

    // The bank bit is the MSB of the flat array address.
    logic [2*W-1:0] mem_q [2**(N+1)];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    assign rd_data = mem_q[{rd_bank, rd_addr}];

endmodule

// File: rtl/fft_reorder_buf.sv
// fft_reorder_buf: ping-pong buffer that turns bit-reversed FFT output frames
// of 2^N complex samples into natural bin order on a valid/ready stream.
//   clk, rst (sync, active high)
//   in_start/in_valid/in_re/in_im - input frame, sample 0 marked by in_start
//   out_valid/out_ready           - output handshake
//   out_start/out_last/out_idx    - frame markers and natural bin index
//   out_re/out_im                 - output sample
//   drop                          - one-cycle pulse when an input frame is discarded
// Optional macro FFT_REORDER_STATS_EN adds frame_cnt (wrapping count of
// completed output frames) and drop_cnt (saturating count of drop pulses).
module fft_reorder_buf
    import fft_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_start,
    input  logic         in_valid,
    input  logic [W-1:0] in_re,
    input  logic [W-1:0] in_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_start,
    output logic         out_last,
    output logic [N-1:0] out_idx,
    output logic [W-1:0] out_re,
    output logic [W-1:0] out_im,
`ifdef FFT_REORDER_STATS_EN
    output logic [15:0]  frame_cnt,
    output logic [15:0]  drop_cnt,
`endif
    output logic         drop
);

    localparam logic [N-1:0] LAST_IDX = {N{1'b1}};

    wr_state_e      state_q, state_d;
    logic [N-1:0]   k_q, k_d;
    logic [N-1:0]   j_q, j_d;
    logic           wr_bank_q, wr_bank_d;
    logic           rd_bank_q, rd_bank_d;
    logic [1:0]     full_q, full_d;
    logic           out_valid_q, out_valid_d;
    logic           out_start_q, out_start_d;
    logic           out_last_q, out_last_d;
    logic [N-1:0]   out_idx_q, out_idx_d;
    logic [W-1:0]   out_re_q, out_re_d;
    logic [W-1:0]   out_im_q, out_im_d;
    logic           drop_q, drop_d;

    logic           wr_en;
    logic [N-1:0]   wr_addr;
    logic [11:0]    rev_k;
    logic           set_full;
    logic           release_rd;
    logic           bank_busy;
    logic           load;
    logic [2*W-1:0] rd_data;

    fft_pp_ram #(.N(N), .W(W)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_bank (wr_bank_q),
        .wr_addr (wr_addr),
        .wr_data ({in_re, in_im}),
        .rd_bank (rd_bank_d),
        .rd_addr (j_q),
        .rd_data (rd_data)
    );

    // A bank handed back by the reader this cycle counts as free, so a new
    // frame arriving at that moment is accepted instead of dropped.
    assign release_rd = out_valid_q && out_ready && out_last_q;
    assign bank_busy  = full_q[wr_bank_q] && !(release_rd && (rd_bank_q == wr_bank_q));

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        wr_bank_d = wr_bank_q;
        wr_en     = 1'b0;
        wr_addr   = '0;
        set_full  = 1'b0;
        drop_d    = 1'b0;
        rev_k     = bitrev(12'(k_q), N);
        case (state_q)
            FILL: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (in_start) begin
                        // Restart in the same bank; the partial frame is overwritten.
                        wr_addr = '0;
                        k_d     = N'(1);
                    end else begin
                        wr_addr = rev_k[N-1:0];
                        if (k_q == LAST_IDX) begin
                            set_full  = 1'b1;
                            wr_bank_d = ~wr_bank_q;
                            k_d       = '0;
                            state_d   = IDLE;
                        end else begin
                            k_d = k_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                if (in_valid && in_start) begin
                    if (bank_busy) begin
                        drop_d  = 1'b1;
                        state_d = DROP;
                    end else begin
                        wr_en   = 1'b1;
                        wr_addr = '0;
                        k_d     = N'(1);
                        state_d = FILL;
                    end
                end
            end
        endcase
    end

    // On a release the read side already points at the other bank, so the
    // next frame can be loaded in the same cycle without a bubble.
    always_comb begin
        rd_bank_d   = release_rd ? ~rd_bank_q : rd_bank_q;
        full_d      = full_q;
        j_d         = j_q;
        out_valid_d = out_valid_q;
        out_start_d = out_start_q;
        out_last_d  = out_last_q;
        out_idx_d   = out_idx_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        if (release_rd) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (set_full) begin
            full_d[wr_bank_q] = 1'b1;
        end
        load = full_q[rd_bank_d] && (!out_valid_q || out_ready);
        if (load) begin
            out_valid_d = 1'b1;
            out_re_d    = rd_data[2*W-1:W];
            out_im_d    = rd_data[W-1:0];
            out_idx_d   = j_q;
            out_start_d = (j_q == '0);
            out_last_d  = (j_q == LAST_IDX);
            j_d         = j_q + 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            j_q         <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            out_valid_q <= 1'b0;
            out_start_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            j_q         <= j_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            out_start_q <= out_start_d;
            out_last_q  <= out_last_d;
            out_idx_q   <= out_idx_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            drop_q      <= drop_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_start = out_start_q;
    assign out_last  = out_last_q;
    assign out_idx   = out_idx_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign drop      = drop_q;

`ifdef FFT_REORDER_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // frame_cnt wraps naturally; drop_cnt sticks at all-ones.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (release_rd) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (drop_d && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fft_reorder_buf.sv
// tb_fft_reorder_buf: directed self-checking bench for fft_reorder_buf (N=4, W=16).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_fft_reorder_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_re = '0;
    logic [15:0] in_im = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic        out_start;
    logic        out_last;
    logic [3:0]  out_idx;
    logic [15:0] out_re;
    logic [15:0] out_im;
    logic        drop;
`ifdef FFT_REORDER_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Natural bin j holds the sample written at input position rev_tab[j].
    int rev_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    logic [15:0] q_re [$];
    logic [15:0] q_im [$];
    logic [3:0]  q_idx [$];
    logic        q_start [$];
    logic        q_last [$];
    int          drop_cycles;
    int          call_no;
    int          first_valid_call;

    fft_reorder_buf #(.N(4), .W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_start  (in_start),
        .in_valid  (in_valid),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_start (out_start),
        .out_last  (out_last),
        .out_idx   (out_idx),
        .out_re    (out_re),
        .out_im    (out_im),
`ifdef FFT_REORDER_STATS_EN
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt),
`endif
        .drop      (drop)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task clear_log();
        q_re.delete();
        q_im.delete();
        q_idx.delete();
        q_start.delete();
        q_last.delete();
        drop_cycles      = 0;
        call_no          = 0;
        first_valid_call = -1;
    endtask

    // Drives one cycle of inputs, logs any transfer and drop seen this cycle,
    // then advances to 1 time unit after the next rising edge.
    task cycle(input logic v, input logic s, input logic [15:0] re,
               input logic [15:0] im, input logic rdy);
        in_valid  = v;
        in_start  = s;
        in_re     = re;
        in_im     = im;
        out_ready = rdy;
        if (out_valid === 1'b1 && first_valid_call < 0) first_valid_call = call_no;
        if (out_valid === 1'b1 && rdy) begin
            q_re.push_back(out_re);
            q_im.push_back(out_im);
            q_idx.push_back(out_idx);
            q_start.push_back(out_start);
            q_last.push_back(out_last);
        end
        if (drop === 1'b1) drop_cycles++;
        call_no++;
        @(posedge clk);
        #1;
    endtask

    task test_reset();
        rst = 1'b1;
        cycle(0, 0, 16'h0, 16'h0, 0);
        cycle(0, 0, 16'h0, 16'h0, 0);
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || drop !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: out_valid=%b drop=%b expected 0 0", out_valid, drop);
        end
        n_checks++;
        if (out_re !== 16'h0 || out_im !== 16'h0 || out_idx !== 4'h0 ||
            out_start !== 1'b0 || out_last !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: re=%h im=%h idx=%0d start=%b last=%b expected all 0",
                     out_re, out_im, out_idx, out_start, out_last);
        end
    endtask

    task test_single_frame();
        logic [15:0] exp_re;
        int last_in;
        clear_log();
        for (int k = 0; k < 16; k++) cycle(1, k == 0, 16'(k), 16'(-k), 1);
        last_in = call_no - 1;
        repeat (24) cycle(0, 0, 16'h0, 16'h0, 1);
        n_checks++;
        if (first_valid_call - last_in != 2) begin
            n_fail++;
            $display("[TB] FAIL single_latency: got %0d cycles expected 2", first_valid_call - last_in);
        end
        n_checks++;
        if (q_re.size() != 16) begin
            n_fail++;
            $display("[TB] FAIL single_count: got %0d outputs expected 16", q_re.size());
        end
        for (int j = 0; j < 16 && j < q_re.size(); j++) begin
            exp_re = 16'(rev_tab[j]);
            n_checks++;
            if (q_re[j] !== exp_re || q_im[j] !== 16'(16'h0 - exp_re) || q_idx[j] !== 4'(j) ||
                q_start[j] !== (j == 0) || q_last[j] !== (j == 15)) begin
                n_fail++;
                $display("[TB] FAIL single_out[%0d]: got re=%h im=%h idx=%0d s=%b l=%b expected re=%h im=%h idx=%0d s=%b l=%b",
                         j, q_re[j], q_im[j], q_idx[j], q_start[j], q_last[j],
                         exp_re, 16'(16'h0 - exp_re), j, (j == 0), (j == 15));
            end
        end
        n_checks++;
        if (drop_cycles != 0) begin
            n_fail++;
            $display("[TB] FAIL single_drop: got %0d drop cycles expected 0", drop_cycles);
        end
    endtask

    task test_back_to_back();
        logic [15:0] exp_re;
        clear_log();
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < 16; k++) cycle(1, k == 0, 16'(16 * f + k), 16'(-(16 * f + k)), 1);
        repeat (40) cycle(0, 0, 16'h0, 16'h0, 1);
        n_checks++;
        if (q_re.size() != 48 || drop_cycles != 0) begin
            n_fail++;
            $display("[TB] FAIL b2b_count: got %0d outputs %0d drops expected 48 0", q_re.size(), drop_cycles);
        end
        for (int i = 0; i < 48 && i < q_re.size(); i++) begin
            exp_re = 16'(16 * (i / 16) + rev_tab[i % 16]);
            n_checks++;
            if (q_re[i] !== exp_re || q_im[i] !== 16'(16'h0 - exp_re) || q_idx[i] !== 4'(i % 16)) begin
                n_fail++;
                $display("[TB] FAIL b2b_out[%0d]: got re=%h im=%h idx=%0d expected re=%h im=%h idx=%0d",
                         i, q_re[i], q_im[i], q_idx[i], exp_re, 16'(16'h0 - exp_re), i % 16);
            end
        end
    endtask

    task test_stall_drop();
        logic [15:0] exp_re;
        clear_log();
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < 16; k++) cycle(1, k == 0, 16'(16 * f + k), 16'(-(16 * f + k)), 0);
        repeat (4) cycle(0, 0, 16'h0, 16'h0, 0);
        n_checks++;
        if (drop_cycles != 1) begin
            n_fail++;
            $display("[TB] FAIL stall_drop_pulse: got %0d drop cycles expected 1", drop_cycles);
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_idx !== 4'd0 || out_re !== 16'h0 || out_start !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL stall_hold_head: got v=%b idx=%0d re=%h s=%b expected 1 0 0000 1",
                     out_valid, out_idx, out_re, out_start);
        end
        repeat (60) cycle(0, 0, 16'h0, 16'h0, 1);
        n_checks++;
        if (q_re.size() != 32) begin
            n_fail++;
            $display("[TB] FAIL stall_count: got %0d outputs expected 32", q_re.size());
        end
        for (int i = 0; i < 32 && i < q_re.size(); i++) begin
            exp_re = 16'(16 * (i / 16) + rev_tab[i % 16]);
            n_checks++;
            if (q_re[i] !== exp_re || q_im[i] !== 16'(16'h0 - exp_re) || q_idx[i] !== 4'(i % 16)) begin
                n_fail++;
                $display("[TB] FAIL stall_out[%0d]: got re=%h im=%h idx=%0d expected re=%h im=%h idx=%0d",
                         i, q_re[i], q_im[i], q_idx[i], exp_re, 16'(16'h0 - exp_re), i % 16);
            end
        end
    endtask

    task test_random_ready();
        logic        rdy, p_valid, p_rdy, p_start, p_last;
        logic [15:0] p_re, p_im, exp_re;
        logic [3:0]  p_idx;
        clear_log();
        p_valid = 1'b0;
        p_rdy   = 1'b1;
        p_re = '0; p_im = '0; p_idx = '0; p_start = 1'b0; p_last = 1'b0;
        for (int c = 0; c < 100; c++) begin
            rdy = (c >= 80) ? 1'b1 : 1'(($urandom_range(0, 1)));
            if (p_valid && !p_rdy) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_re !== p_re || out_im !== p_im ||
                    out_idx !== p_idx || out_start !== p_start || out_last !== p_last) begin
                    n_fail++;
                    $display("[TB] FAIL rand_hold[%0d]: got v=%b re=%h idx=%0d expected v=1 re=%h idx=%0d",
                             c, out_valid, out_re, out_idx, p_re, p_idx);
                end
            end
            p_valid = out_valid; p_rdy = rdy; p_re = out_re; p_im = out_im;
            p_idx = out_idx; p_start = out_start; p_last = out_last;
            if (c < 16) cycle(1, c == 0, 16'(200 + c), 16'(3 * c), rdy);
            else        cycle(0, 0, 16'h0, 16'h0, rdy);
        end
        n_checks++;
        if (q_re.size() != 16) begin
            n_fail++;
            $display("[TB] FAIL rand_count: got %0d outputs expected 16", q_re.size());
        end
        for (int j = 0; j < 16 && j < q_re.size(); j++) begin
            exp_re = 16'(200 + rev_tab[j]);
            n_checks++;
            if (q_re[j] !== exp_re || q_im[j] !== 16'(3 * rev_tab[j]) || q_idx[j] !== 4'(j)) begin
                n_fail++;
                $display("[TB] FAIL rand_out[%0d]: got re=%h im=%h idx=%0d expected re=%h im=%h idx=%0d",
                         j, q_re[j], q_im[j], q_idx[j], exp_re, 16'(3 * rev_tab[j]), j);
            end
        end
    endtask

    task test_restart();
        logic [15:0] exp_re;
        clear_log();
        for (int k = 0; k < 7; k++)  cycle(1, k == 0, 16'(k), 16'(-k), 1);
        for (int k = 0; k < 16; k++) cycle(1, k == 0, 16'(100 + k), 16'(-(100 + k)), 1);
        repeat (24) cycle(0, 0, 16'h0, 16'h0, 1);
        n_checks++;
        if (q_re.size() != 16 || drop_cycles != 0) begin
            n_fail++;
            $display("[TB] FAIL restart_count: got %0d outputs %0d drops expected 16 0", q_re.size(), drop_cycles);
        end
        for (int j = 0; j < 16 && j < q_re.size(); j++) begin
            exp_re = 16'(100 + rev_tab[j]);
            n_checks++;
            if (q_re[j] !== exp_re || q_im[j] !== 16'(16'h0 - exp_re) || q_idx[j] !== 4'(j)) begin
                n_fail++;
                $display("[TB] FAIL restart_out[%0d]: got re=%h im=%h idx=%0d expected re=%h im=%h idx=%0d",
                         j, q_re[j], q_im[j], q_idx[j], exp_re, 16'(16'h0 - exp_re), j);
            end
        end
    endtask

    task test_reset_mid();
        logic        found;
        logic [15:0] exp_re;
        clear_log();
        for (int k = 0; k < 16; k++) cycle(1, k == 0, 16'(50 + k), 16'(-(50 + k)), 1);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (out_valid === 1'b1 && out_idx === 4'd5) found = 1'b1;
            else cycle(0, 0, 16'h0, 16'h0, 1);
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("[TB] FAIL rstmid_reach_j5: got no idx 5 within 40 cycles expected idx 5");
        end
        rst = 1'b1;
        cycle(0, 0, 16'h0, 16'h0, 1);
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || out_re !== 16'h0 || out_im !== 16'h0 || out_idx !== 4'h0 ||
            out_start !== 1'b0 || out_last !== 1'b0 || drop !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rstmid_zero: got v=%b re=%h im=%h idx=%0d s=%b l=%b d=%b expected all 0",
                     out_valid, out_re, out_im, out_idx, out_start, out_last, drop);
        end
`ifdef FFT_REORDER_STATS_EN
        n_checks++;
        if (frame_cnt !== 16'h0 || drop_cnt !== 16'h0) begin
            n_fail++;
            $display("[TB] FAIL rstmid_stats: got frame_cnt=%0d drop_cnt=%0d expected 0 0", frame_cnt, drop_cnt);
        end
`endif
        clear_log();
        for (int k = 0; k < 16; k++) cycle(1, k == 0, 16'(300 + k), 16'(-(300 + k)), 1);
        repeat (24) cycle(0, 0, 16'h0, 16'h0, 1);
        n_checks++;
        if (q_re.size() != 16) begin
            n_fail++;
            $display("[TB] FAIL rstmid_count: got %0d outputs expected 16", q_re.size());
        end
        for (int j = 0; j < 16 && j < q_re.size(); j++) begin
            exp_re = 16'(300 + rev_tab[j]);
            n_checks++;
            if (q_re[j] !== exp_re || q_im[j] !== 16'(16'h0 - exp_re) || q_idx[j] !== 4'(j)) begin
                n_fail++;
                $display("[TB] FAIL rstmid_out[%0d]: got re=%h im=%h idx=%0d expected re=%h im=%h idx=%0d",
                         j, q_re[j], q_im[j], q_idx[j], exp_re, 16'(16'h0 - exp_re), j);
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stall_drop();
        test_random_ready();
        test_restart();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
